btn_debounce_pulse: RTL

//  Cleans one raw push-button input and produces a debounced level plus single-cycle

---
 rtl/btn_debounce_pulse.sv | 112 +++++++++++
 1 files changed

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a 4-state FSM
// producing a debounced level plus single-cycle press/release strobes.
module btn_debounce_pulse #(
  parameter int STABLE_COUNT = 1_000_000,
  parameter int CNT_WIDTH    = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic                 r_press;
  logic                 r_release;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM; strobes default low and are raised only on an accepted change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_LOW: begin
          r_cnt <= '0;
          if (r_sync2) begin
            r_state <= S_RISE_WAIT;
          end else begin
            r_state <= S_LOW;
          end
        end
        S_RISE_WAIT: begin
          if (!r_sync2) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_HIGH;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          r_cnt <= '0;
          if (!r_sync2) begin
            r_state <= S_FALL_WAIT;
          end else begin
            r_state <= S_HIGH;
          end
        end
        S_FALL_WAIT: begin
          // A return to 1 cancels the release without any strobe
          if (r_sync2) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= S_LOW;
            r_level   <= 1'b0;
            r_release <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule
